// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1) from a sysid slave, compares both against
// expected values and reports pass/fail/timeout to boot or health logic.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'd1519144068,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 2,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int                 RETRY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
   localparam logic [15:0]        TCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ID_REQ  = 3'd1,
      ID_WAIT = 3'd2,
      TS_REQ  = 3'd3,
      TS_WAIT = 3'd4,
      FINISH  = 3'd5
   } state_t;

   state_t               state;
   state_t               state_n;
   logic [15:0]          tcnt;
   logic [RETRY_W-1:0]   retry_cnt;
   logic                 auto_pend;

   logic                 launch;
   logic                 cap_id;
   logic                 cap_ts;
   logic                 expired;
   logic                 tmo_hit;
   logic                 retry;
   logic                 give_up;
   logic                 in_xfer;

   // State register; reset forces IDLE so avm_read drops on the next edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode, bus outputs and per-cycle control strobes.
   always_comb begin
      state_n     = state;
      avm_read    = 1'b0;
      avm_address = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      launch      = 1'b0;
      cap_id      = 1'b0;
      cap_ts      = 1'b0;
      tmo_hit     = 1'b0;
      retry       = 1'b0;
      give_up     = 1'b0;
      in_xfer     = 1'b0;
      // A request accepted on its last allowed cycle still gets one WAIT
      // cycle to deliver data, hence >= rather than ==.
      expired     = (tcnt >= TCNT_LAST);

      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start || auto_pend) begin
               launch  = 1'b1;
               state_n = ID_REQ;
            end
         end
         ID_REQ: begin
            in_xfer  = 1'b1;
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               state_n = ID_WAIT;
            end else if (expired) begin
               tmo_hit = 1'b1;
            end
         end
         ID_WAIT: begin
            in_xfer = 1'b1;
            if (avm_readdatavalid) begin
               cap_id  = 1'b1;
               state_n = TS_REQ;
            end else if (expired) begin
               tmo_hit = 1'b1;
            end
         end
         TS_REQ: begin
            in_xfer     = 1'b1;
            avm_read    = 1'b1;
            avm_address = 1'b1;
            if (!avm_waitrequest) begin
               state_n = TS_WAIT;
            end else if (expired) begin
               tmo_hit = 1'b1;
            end
         end
         TS_WAIT: begin
            in_xfer = 1'b1;
            if (avm_readdatavalid) begin
               cap_ts  = 1'b1;
               state_n = FINISH;
            end else if (expired) begin
               tmo_hit = 1'b1;
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Retries reissue the same word; the budget is shared by both words.
      if (tmo_hit) begin
         if (retry_cnt < RETRY_MAX) begin
            retry   = 1'b1;
            state_n = (state == ID_REQ || state == ID_WAIT) ? ID_REQ : TS_REQ;
         end else begin
            give_up = 1'b1;
            state_n = FINISH;
         end
      end
   end

   // Counters, captured words and sticky result flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         tcnt      <= '0;
         retry_cnt <= '0;
         auto_pend <= AUTO_START;
         id_ok     <= 1'b0;
         ts_ok     <= 1'b0;
         timeout   <= 1'b0;
         id_value  <= '0;
         ts_value  <= '0;
      end else begin
         // Auto start is only honoured on the first cycle after reset.
         auto_pend <= 1'b0;

         if (launch || retry || cap_id) begin
            tcnt <= '0;
         end else if (in_xfer) begin
            tcnt <= tcnt + 16'd1;
         end

         if (launch) begin
            retry_cnt <= '0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
         end else begin
            if (retry) begin
               retry_cnt <= retry_cnt + RETRY_W'(1);
            end
            if (give_up) begin
               timeout <= 1'b1;
            end
            if (cap_id) begin
               id_value <= avm_readdata;
               if (avm_readdata == EXPECTED_ID) begin
                  id_ok <= 1'b1;
               end
            end
            if (cap_ts) begin
               ts_value <= avm_readdata;
               if (avm_readdata == EXPECTED_TS) begin
                  ts_ok <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that performs the system-ID read from the requester side.
- Reads word 0 (system ID) and word 1 (build timestamp) from a sysid-style control slave, then compares both values against parameterised expected values.
- Reports pass/fail/timeout status to boot or health-monitor logic.
- Sits between the interconnect and the board-level status LEDs or the bring-up controller.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected value at word address 0.
- EXPECTED_TS, 32'd1519144068, expected value at word address 1.
- TIMEOUT_CYCLES, 255, maximum cycles allowed per read transaction (request plus data phase); range 1..65535.
- MAX_RETRIES, 2, number of times a timed-out transaction is reissued before the checker gives up.
- AUTO_START, 1, when set, a check begins automatically on the first cycle after reset is released.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that requests a check.
- avm_address  out  1  word address (0 = ID, 1 = timestamp).
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read data strobe.
- avm_readdata  in  32  read data.
- busy  out  1  high while a check is in progress.
- done  out  1  one-cycle pulse when a check completes, whether it passed or failed.
- id_ok  out  1  sticky flag: the ID read matched EXPECTED_ID.
- ts_ok  out  1  sticky flag: the timestamp read matched EXPECTED_TS.
- timeout  out  1  sticky flag: retries were exhausted.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high, named `reset`.
- Reset values: all outputs are 0; the state is IDLE and the counters are cleared. When reset is asserted mid-transaction, avm_read is 0 from the next edge, and the result registers and flags are cleared.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE:
  - Exits on a start pulse.
  - Also exits on the first post-reset cycle when AUTO_START = 1.
  - On exit: clear id_ok, ts_ok, timeout, the retry counter and the timeout counter; go to ID_REQ.
- start while busy is ignored and is not queued.
- ID_REQ / TS_REQ:
  - Drive avm_read = 1, with avm_address = 0 or 1 respectively.
  - Hold avm_read and avm_address stable while avm_waitrequest = 1.
  - The request is accepted on an edge where avm_read = 1 and avm_waitrequest = 0; the next state is the matching *_WAIT state and avm_read drops to 0.
- ID_WAIT / TS_WAIT:
  - On avm_readdatavalid = 1, capture avm_readdata into id_value or ts_value.
  - Set id_ok or ts_ok if the captured value equals the corresponding expected parameter (32-bit equality).
  - ID_WAIT then advances to TS_REQ; TS_WAIT advances to FINISH.
  - Data is accepted in the same cycle as the request is accepted only if it arrives in a WAIT state. avm_readdatavalid seen in any other state (stray or late response) is ignored and captures nothing.
- Timeout counter:
  - Cleared on entry to each REQ state; increments each cycle spent in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without data:
    - If retries used < MAX_RETRIES: increment the retry count, clear the counter, and re-enter the same REQ state (same address).
    - Otherwise: set timeout = 1 and go to FINISH; the flags for unread words remain 0.
  - The retry count is shared across both words and is not reset between them.
- FINISH: done = 1 for exactly one cycle, then go to IDLE.
- busy = 1 in every state except IDLE. Values and flags hold until the next check starts or reset is applied.
- Latency: with zero waitrequest and readdatavalid one cycle after acceptance, done asserts 5 cycles after start is sampled (ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH).
- Only one outstanding read at a time; there is no pipelining.

Test Plan:
- AUTO_START = 1 with a zero-wait sysid model (ID 0, TS 1519144068) → reads at addresses 0 then 1; done pulses once; id_ok = 1, ts_ok = 1, timeout = 0, ts_value = 1519144068.
- Slave returns ID 32'h1 → id_ok = 0, ts_ok = 1, id_value = 1; done still pulses exactly once.
- waitrequest held for 7 cycles on address 1 → avm_read and address stay stable throughout; exactly one request is accepted; the result is a pass.
- Slave never responds with TIMEOUT_CYCLES = 10 and MAX_RETRIES = 2 → exactly 3 requests at address 0; timeout = 1 at FINISH, about 30 cycles after start; id_ok = 0, ts_ok = 0.
- Reset asserted in TS_WAIT, then start issued later → all outputs read 0 after the reset edge; the new check completes normally; a stray readdatavalid while IDLE changes nothing.
- start pulsed while busy → ignored; only one done pulse per accepted start.
